// File: rtl/hv_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, sync, strobes, field.
// Blanked RGB output is registered on the pixel clock-enable.
module hv_timing_gen #(
    parameter int CW            = 9,
    parameter int RGBW          = 12,
    parameter int H_BLANK_END   = 0,
    parameter int H_BLANK_START = 289,
    parameter int H_SYNC_START  = 311,
    parameter int H_SYNC_END    = 342,
    parameter int H_SKIP_TO     = 471,
    parameter int H_MAX         = 511,
    parameter int V_BLANK_START = 223,
    parameter int V_SYNC_START  = 235,
    parameter int V_SYNC_END    = 242,
    parameter int V_SKIP_TO     = 492,
    parameter int V_MAX         = 511,
    parameter bit HS_POL        = 1'b0,
    parameter bit VS_POL        = 1'b0
) (
    input  logic            MCLK,
    input  logic            RESET,
    input  logic            PCE,
    input  logic [RGBW-1:0] iRGB,
    output logic [CW-1:0]   HPOS,
    output logic [CW-1:0]   VPOS,
    output logic [RGBW-1:0] oRGB,
    output logic            HBLK,
    output logic            VBLK,
    output logic            HSYN,
    output logic            VSYN,
    output logic            LINE_STB,
    output logic            FRAME_STB,
    output logic            FIELD
);

    localparam logic [CW-1:0] HBE = CW'(H_BLANK_END);
    localparam logic [CW-1:0] HBS = CW'(H_BLANK_START);
    localparam logic [CW-1:0] HSS = CW'(H_SYNC_START);
    localparam logic [CW-1:0] HSE = CW'(H_SYNC_END);
    localparam logic [CW-1:0] HSK = CW'(H_SKIP_TO);
    localparam logic [CW-1:0] HMX = CW'(H_MAX);
    localparam logic [CW-1:0] VBS = CW'(V_BLANK_START);
    localparam logic [CW-1:0] VSS = CW'(V_SYNC_START);
    localparam logic [CW-1:0] VSE = CW'(V_SYNC_END);
    localparam logic [CW-1:0] VSK = CW'(V_SKIP_TO);
    localparam logic [CW-1:0] VMX = CW'(V_MAX);

    logic [CW-1:0]   hpos_q, hpos_d;
    logic [CW-1:0]   vpos_q, vpos_d;
    logic [RGBW-1:0] rgb_q, rgb_d;
    logic            hblk_q, hblk_d;
    logic            vblk_q, vblk_d;
    logic            hsyn_q, hsyn_d;
    logic            vsyn_q, vsyn_d;
    logic            lstb_q, lstb_d;
    logic            fstb_q, fstb_d;
    logic            field_q, field_d;

    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        rgb_d   = rgb_q;
        hblk_d  = hblk_q;
        vblk_d  = vblk_q;
        hsyn_d  = hsyn_q;
        vsyn_d  = vsyn_q;
        field_d = field_q;
        lstb_d  = 1'b0;
        fstb_d  = 1'b0;
        if (PCE) begin
            // blanking decision uses the flags as they stood before this edge
            rgb_d  = (hblk_q | vblk_q) ? '0 : iRGB;
            hpos_d = hpos_q + 1'b1;
            unique case (1'b1)
                hpos_q == HBE: hblk_d = 1'b0;
                hpos_q == HBS: hblk_d = 1'b1;
                hpos_q == HSS: hsyn_d = HS_POL;
                hpos_q == HSE: begin
                    hsyn_d = ~HS_POL;
                    hpos_d = HSK;
                end
                hpos_q == HMX: begin
                    hpos_d = '0;
                    lstb_d = 1'b1;
                    vpos_d = vpos_q + 1'b1;
                    unique case (1'b1)
                        vpos_q == VBS: vblk_d = 1'b1;
                        vpos_q == VSS: vsyn_d = VS_POL;
                        vpos_q == VSE: begin
                            vsyn_d = ~VS_POL;
                            vpos_d = VSK;
                        end
                        vpos_q == VMX: begin
                            vblk_d  = 1'b0;
                            vpos_d  = '0;
                            field_d = ~field_q;
                            fstb_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            rgb_q   <= '0;
            hblk_q  <= 1'b1;
            vblk_q  <= 1'b1;
            hsyn_q  <= ~HS_POL;
            vsyn_q  <= ~VS_POL;
            lstb_q  <= 1'b0;
            fstb_q  <= 1'b0;
            field_q <= 1'b0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            rgb_q   <= rgb_d;
            hblk_q  <= hblk_d;
            vblk_q  <= vblk_d;
            hsyn_q  <= hsyn_d;
            vsyn_q  <= vsyn_d;
            lstb_q  <= lstb_d;
            fstb_q  <= fstb_d;
            field_q <= field_d;
        end
    end

    assign HPOS      = hpos_q;
    assign VPOS      = vpos_q;
    assign oRGB      = rgb_q;
    assign HBLK      = hblk_q;
    assign VBLK      = vblk_q;
    assign HSYN      = hsyn_q;
    assign VSYN      = vsyn_q;
    assign LINE_STB  = lstb_q;
    assign FRAME_STB = fstb_q;
    assign FIELD     = field_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Bench for hv_timing_gen: default raster and a small 10x10 raster run side by side.
// Outputs are predicted from the count of enabled edges since reset.
module tb_hv_timing_gen;

    typedef struct {
        int hbe, hbs, hss, hse, hsk, hmx;
        int vbs, vss, vse, vsk, vmx;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        bit valid;
        int n;
        bit en;
        int rgb;
    } mst_t;

    typedef struct {
        int hpos, vpos, rgb, hblk, vblk;
        int hsyn, vsyn, ls, fs, field;
    } out_t;

    cfg_t dc = '{0, 289, 311, 342, 471, 511, 223, 235, 242, 492, 511, 1'b0, 1'b0};
    cfg_t sc = '{0, 2, 4, 6, 8, 9, 2, 3, 5, 7, 9, 1'b1, 1'b1};
    mst_t dm = '{1'b0, 0, 1'b0, 0};
    mst_t sm = '{1'b0, 0, 1'b0, 0};

    int vectors = 0;
    int miscompares = 0;

    logic MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    logic        d_rst, d_pce;
    logic [11:0] d_rgb, d_orgb;
    logic [8:0]  d_hpos, d_vpos;
    logic        d_hblk, d_vblk, d_hsyn, d_vsyn, d_ls, d_fs, d_field;

    logic        s_rst, s_pce;
    logic [3:0]  s_rgb, s_orgb;
    logic [3:0]  s_hpos, s_vpos;
    logic        s_hblk, s_vblk, s_hsyn, s_vsyn, s_ls, s_fs, s_field;

    hv_timing_gen u_def (
        .MCLK(MCLK), .RESET(d_rst), .PCE(d_pce), .iRGB(d_rgb),
        .HPOS(d_hpos), .VPOS(d_vpos), .oRGB(d_orgb),
        .HBLK(d_hblk), .VBLK(d_vblk), .HSYN(d_hsyn), .VSYN(d_vsyn),
        .LINE_STB(d_ls), .FRAME_STB(d_fs), .FIELD(d_field)
    );

    hv_timing_gen #(
        .CW(4), .RGBW(4),
        .H_BLANK_END(0), .H_BLANK_START(2), .H_SYNC_START(4),
        .H_SYNC_END(6), .H_SKIP_TO(8), .H_MAX(9),
        .V_BLANK_START(2), .V_SYNC_START(3), .V_SYNC_END(5),
        .V_SKIP_TO(7), .V_MAX(9),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_small (
        .MCLK(MCLK), .RESET(s_rst), .PCE(s_pce), .iRGB(s_rgb),
        .HPOS(s_hpos), .VPOS(s_vpos), .oRGB(s_orgb),
        .HBLK(s_hblk), .VBLK(s_vblk), .HSYN(s_hsyn), .VSYN(s_vsyn),
        .LINE_STB(s_ls), .FRAME_STB(s_fs), .FIELD(s_field)
    );

    function automatic int llen(cfg_t c);
        return (c.hse + 1) + (c.hmx - c.hsk + 1);
    endfunction

    function automatic int flen(cfg_t c);
        return (c.vse + 1) + (c.vmx - c.vsk + 1);
    endfunction

    // position within the line/frame -> counter value, skipping the jump gap
    function automatic int hmap(cfg_t c, int p);
        return (p <= c.hse) ? p : c.hsk + p - c.hse - 1;
    endfunction

    function automatic int vmap(cfg_t c, int l);
        return (l <= c.vse) ? l : c.vsk + l - c.vse - 1;
    endfunction

    function automatic out_t model(cfg_t c, mst_t m);
        out_t o;
        int ll, fl, p, lc, hp, vp;
        ll = llen(c);
        fl = flen(c);
        p  = m.n % ll;
        lc = m.n / ll;
        o.hpos = hmap(c, p);
        o.vpos = vmap(c, lc % fl);
        o.rgb  = m.rgb;
        if (m.n == 0) begin
            o.hblk = 1;
            o.hsyn = int'(!c.hpol);
        end else begin
            hp = hmap(c, (m.n - 1) % ll);
            o.hblk = (hp >= c.hbe && hp < c.hbs) ? 0 : 1;
            o.hsyn = (hp >= c.hss && hp < c.hse) ? int'(c.hpol) : int'(!c.hpol);
        end
        if (lc == 0) begin
            o.vblk = 1;
            o.vsyn = int'(!c.vpol);
        end else begin
            vp = vmap(c, (lc - 1) % fl);
            o.vblk = (lc < fl || (vp >= c.vbs && vp < c.vmx)) ? 1 : 0;
            o.vsyn = (vp >= c.vss && vp < c.vse) ? int'(c.vpol) : int'(!c.vpol);
        end
        o.field = (lc / fl) % 2;
        o.ls = (m.en && p == 0) ? 1 : 0;
        o.fs = (m.en && p == 0 && (lc % fl) == 0) ? 1 : 0;
        return o;
    endfunction

    function automatic mst_t step(cfg_t c, mst_t m, bit rst, bit pce, int rgb);
        mst_t r;
        out_t o;
        r = m;
        r.en = 1'b0;
        if (rst) begin
            r.valid = 1'b1;
            r.n = 0;
            r.rgb = 0;
        end else if (m.valid && pce) begin
            o = model(c, m);
            r.rgb = (o.hblk != 0 || o.vblk != 0) ? 0 : rgb;
            r.n = m.n + 1;
            r.en = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp(string t, out_t a, out_t e);
        chk({t, ".HPOS"}, a.hpos, e.hpos);
        chk({t, ".VPOS"}, a.vpos, e.vpos);
        chk({t, ".oRGB"}, a.rgb, e.rgb);
        chk({t, ".HBLK"}, a.hblk, e.hblk);
        chk({t, ".VBLK"}, a.vblk, e.vblk);
        chk({t, ".HSYN"}, a.hsyn, e.hsyn);
        chk({t, ".VSYN"}, a.vsyn, e.vsyn);
        chk({t, ".LINE_STB"}, a.ls, e.ls);
        chk({t, ".FRAME_STB"}, a.fs, e.fs);
        chk({t, ".FIELD"}, a.field, e.field);
    endtask

    always @(posedge MCLK) begin
        dm <= step(dc, dm, d_rst, d_pce, int'(d_rgb));
        sm <= step(sc, sm, s_rst, s_pce, int'(s_rgb));
    end

    always @(negedge MCLK) begin : compare
        out_t a;
        if (dm.valid) begin
            a = '{int'(d_hpos), int'(d_vpos), int'(d_orgb), int'(d_hblk),
                  int'(d_vblk), int'(d_hsyn), int'(d_vsyn), int'(d_ls),
                  int'(d_fs), int'(d_field)};
            cmp("D", a, model(dc, dm));
        end
        if (sm.valid) begin
            a = '{int'(s_hpos), int'(s_vpos), int'(s_orgb), int'(s_hblk),
                  int'(s_vblk), int'(s_hsyn), int'(s_vsyn), int'(s_ls),
                  int'(s_fs), int'(s_field)};
            cmp("S", a, model(sc, sm));
        end
    end

    task automatic d_stim();
        int lowcnt;
        int last;
        int gap;
        d_rst = 1'b1;
        d_pce = 1'b0;
        d_rgb = '0;
        repeat (3) @(negedge MCLK);
        chk("D.rst.HPOS", int'(d_hpos), 0);
        chk("D.rst.VPOS", int'(d_vpos), 0);
        chk("D.rst.HBLK", int'(d_hblk), 1);
        chk("D.rst.VBLK", int'(d_vblk), 1);
        chk("D.rst.HSYN", int'(d_hsyn), 1);
        chk("D.rst.VSYN", int'(d_vsyn), 1);
        chk("D.rst.oRGB", int'(d_orgb), 0);
        chk("D.rst.FIELD", int'(d_field), 0);
        d_rst = 1'b0;
        d_pce = 1'b1;
        d_rgb = 12'($urandom);
        lowcnt = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge MCLK);
            d_rgb = 12'($urandom);
            if (k <= 384 && d_hsyn == 1'b0) lowcnt++;
            case (k)
                1: begin
                    chk("D.k1.HPOS", int'(d_hpos), 1);
                    chk("D.k1.HBLK", int'(d_hblk), 0);
                end
                289: chk("D.k289.HBLK", int'(d_hblk), 0);
                290: chk("D.k290.HBLK", int'(d_hblk), 1);
                311: chk("D.k311.HSYN", int'(d_hsyn), 1);
                312: chk("D.k312.HSYN", int'(d_hsyn), 0);
                342: chk("D.k342.HPOS", int'(d_hpos), 342);
                343: chk("D.k343.HPOS", int'(d_hpos), 471);
                384: begin
                    chk("D.k384.HPOS", int'(d_hpos), 0);
                    chk("D.k384.VPOS", int'(d_vpos), 1);
                    chk("D.k384.LINE_STB", int'(d_ls), 1);
                    chk("D.hsync_low", lowcnt, 31);
                end
                385: chk("D.k385.LINE_STB", int'(d_ls), 0);
                default: ;
            endcase
        end
        last = -1;
        gap = -1;
        for (int c = 0; c < 6144; c++) begin
            d_pce = (c % 8) == 7;
            d_rgb = 12'($urandom);
            @(negedge MCLK);
            if (d_ls) begin
                if (last >= 0) gap = c - last;
                last = c;
            end
        end
        chk("D.line_gap_pce8", gap, 3072);
        d_rgb = 12'hFFF;
        for (int c = 0; c < 4000; c++) begin
            d_pce = ($urandom % 2) != 0;
            @(negedge MCLK);
        end
        d_pce = 1'b0;
    endtask

    task automatic s_stim();
        int fcount;
        int lines;
        int w;
        s_rst = 1'b1;
        s_pce = 1'b0;
        s_rgb = '0;
        repeat (2) @(negedge MCLK);
        s_rst = 1'b0;
        fcount = 0;
        lines = 0;
        for (int c = 0; c < 1500; c++) begin
            s_pce = ($urandom % 4) != 0;
            s_rgb = 4'($urandom);
            @(negedge MCLK);
            if (s_ls) lines++;
            if (s_fs) begin
                if (fcount > 0) chk("S.frame_lines", lines, 9);
                fcount++;
                lines = 0;
            end
        end
        chk("S.frames_seen", int'(fcount >= 10), 1);
        s_rgb = 4'hF;
        s_pce = 1'b1;
        repeat (200) @(negedge MCLK);
        w = 0;
        while (s_hpos != 4'd5 && w < 200) begin
            @(negedge MCLK);
            w++;
        end
        chk("S.wait_hpos5", int'(w < 200), 1);
        chk("S.pre_rst.HSYN", int'(s_hsyn), 1);
        s_rst = 1'b1;
        @(negedge MCLK);
        chk("S.rst.HPOS", int'(s_hpos), 0);
        chk("S.rst.VPOS", int'(s_vpos), 0);
        chk("S.rst.HSYN", int'(s_hsyn), 0);
        chk("S.rst.VSYN", int'(s_vsyn), 0);
        chk("S.rst.HBLK", int'(s_hblk), 1);
        chk("S.rst.oRGB", int'(s_orgb), 0);
        s_rst = 1'b0;
        repeat (4) @(negedge MCLK);
        chk("S.after4.HPOS", int'(s_hpos), 4);
        chk("S.after4.HSYN", int'(s_hsyn), 0);
        @(negedge MCLK);
        chk("S.after5.HPOS", int'(s_hpos), 5);
        chk("S.after5.HSYN", int'(s_hsyn), 1);
        for (int c = 0; c < 300; c++) begin
            s_pce = ($urandom % 2) != 0;
            s_rgb = 4'($urandom);
            @(negedge MCLK);
        end
        s_pce = 1'b0;
    endtask

    initial begin
        fork
            d_stim();
            s_stim();
        join
        repeat (2) @(negedge MCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hv_timing_gen.md
# hv_timing_gen

Parametrised raster timing generator for the arcade cores. It produces pixel/line counters, blanking, sync, line/frame strobes and a field toggle, and registers the blanked RGB output. It runs on the system clock, advanced by a pixel clock-enable, and sits between the game core's pixel output and the video scaler/rotator. All counts, sync polarities and colour width are parameters. The defaults reproduce the Gaplus 288x224 raster.

## Interface
Parameters:
- CW, 9: counter width for both counters.
- RGBW, 12: RGB bus width.
- H_BLANK_END, 0: H count at which HBLK deasserts.
- H_BLANK_START, 289: H count at which HBLK asserts.
- H_SYNC_START, 311: H count at which HSYN goes active.
- H_SYNC_END, 342: H count at which HSYN goes inactive; the H counter then jumps to H_SKIP_TO.
- H_SKIP_TO, 471: H jump target.
- H_MAX, 511: last H count; the next H count is 0.
- V_BLANK_START, 223; V_SYNC_START, 235; V_SYNC_END, 242; V_SKIP_TO, 492; V_MAX, 511: vertical equivalents of the H parameters. VBLK deasserts when the V counter leaves V_MAX.
- HS_POL, 0 and VS_POL, 0: active sync level.
- Required ordering: H_BLANK_END < H_BLANK_START < H_SYNC_START < H_SYNC_END < H_SKIP_TO <= H_MAX < 2^CW. V ordering is the same. Behaviour is undefined otherwise.

Ports:
- MCLK, in, 1: the single clock.
- RESET, in, 1: synchronous, active-high.
- PCE, in, 1: pixel clock-enable, one MCLK wide.
- iRGB, in, RGBW: pixel from the core, sampled on PCE.
- HPOS, out, CW: H counter.
- VPOS, out, CW: V counter.
- oRGB, out, RGBW: blanked pixel.
- HBLK, VBLK, out, 1: blanking flags, active high.
- HSYN, VSYN, out, 1: sync outputs, at the polarity set by HS_POL/VS_POL.
- LINE_STB, out, 1: one-MCLK pulse when the H counter wraps to 0.
- FRAME_STB, out, 1: one-MCLK pulse when the V counter wraps to 0.
- FIELD, out, 1: toggles once per frame.

## Operation
- All state updates only on MCLK edges with PCE=1, except LINE_STB and FRAME_STB, which are 0 on every MCLK where they are not pulsing.
- H step: each enabled edge evaluates the current count h (h=HPOS before the edge) and applies the matching rule:
  - h==H_BLANK_END: HBLK<=0.
  - h==H_BLANK_START: HBLK<=1.
  - h==H_SYNC_START: HSYN<=active.
  - h==H_SYNC_END: HSYN<=inactive and HPOS<=H_SKIP_TO.
  - h==H_MAX: HPOS<=0, LINE_STB<=1, V step.
  - Any other h: HPOS<=h+1.
- V step applies only at h==H_MAX and evaluates the current v:
  - v==V_BLANK_START: VBLK<=1.
  - v==V_SYNC_START: VSYN<=active.
  - v==V_SYNC_END: VSYN<=inactive and VPOS<=V_SKIP_TO.
  - v==V_MAX: VBLK<=0, VPOS<=0, FIELD<=~FIELD, FRAME_STB<=1.
  - Any other v: VPOS<=v+1.
- Flags change one enabled edge after the counter holds the trigger value. With defaults, HBLK is 0 while HPOS is 1..289 inclusive.
- oRGB <= (HBLK|VBLK) ? 0 : iRGB on each enabled edge. The decision uses the pre-edge flag values.
- Sync outputs drive HS_POL/VS_POL when active and the inverse when inactive.
- Counters never exceed H_MAX/V_MAX, and counts strictly between H_SYNC_END and H_SKIP_TO are never visited.

## Timing
- Reset values: HPOS=0, VPOS=0, HBLK=1, VBLK=1, HSYN=~HS_POL, VSYN=~VS_POL, oRGB=0, LINE_STB=0, FRAME_STB=0, FIELD=0.
- RESET overrides PCE and takes effect on the first MCLK edge where it is high, including mid-line and mid-sync.
- Line length = (H_SYNC_END+1) + (H_MAX-H_SKIP_TO+1) enabled cycles; the default is 384.
- Frame length = (V_SYNC_END+1) + (V_MAX-V_SKIP_TO+1) lines; the default is 263.
- oRGB latency from iRGB: one enabled edge.
- LINE_STB and FRAME_STB go high on the enabled edge at the wrap and are cleared on the next MCLK edge, whatever PCE is.
- When PCE is held low, every output except the strobes holds indefinitely.
- A simultaneous H wrap and V wrap pulses LINE_STB and FRAME_STB on the same cycle.

## Test plan
- Reset, defaults, PCE=1: after RESET drops, HPOS/VPOS=0, HBLK=VBLK=1, HSYN=VSYN=1. HBLK falls on the edge after HPOS=0 and rises on the edge after HPOS=289.
- Default line length: successive LINE_STB pulses are 384 PCE apart, and HPOS goes 342 -> 471 -> ... -> 511 -> 0. HSYN is low for exactly 31 enabled cycles.
- Default frame length: successive FRAME_STB pulses are 263 lines apart. VSYN is low for 7 lines. FIELD toggles once per frame. VPOS goes 242 -> 492.
- PCE=1 every 8th MCLK: all counts scale by 8. Each strobe is 1 MCLK wide. Outputs stay stable between enables.
- iRGB=0xFFF constant: oRGB=0xFFF only on edges where pre-edge HBLK=0 and VBLK=0, otherwise 0x000.
- Small config (CW=4, H_MAX=9, HS_POL=1, VS_POL=1), with RESET asserted at HPOS=5 during active sync: outputs return to reset values next edge, and the count restarts from 0 with the correct polarity.
